inst_decoder: RTL and testbench

- Combinational x86-64 (long mode, 64-bit code segment) instruction-length decoder.
- Sits between the fetch/decode byte window and the decode-offset advance logic in the core.
- Each cycle it examines a 15-byte window beginning at the current decode offset and reports the length of the first instruction in that window.
- It also keeps a registered count of instructions consumed and a sticky illegal-instruction flag.

---
 rtl/inst_decoder.sv | 223 ++++++++++++++++++++++
 tb/tb_inst_decoder.sv | 113 +++++++++++
 2 files changed

// File: rtl/inst_decoder.sv
// x86-64 long-mode instruction-length decoder with retire count and sticky illegal flag.
// Optional INST_DECODER_TRACE_EN: simulation-only trace of each decoded instruction.
module inst_decoder (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [0:119] decode_bytes,
  output logic [3:0]   bytes_decoded,
  output logic         illegal,
  output logic         has_modrm,
  output logic [1:0]   opcode_map,
  output logic [31:0]  inst_count,
  output logic         illegal_seen
);

  logic [7:0] b [16];
  logic [3:0] pc;
  logic       stop;
  logic       p66;
  logic       p67;
  logic       too_many;
  logic       rex_hit;
  logic       w;
  logic       osz16;
  logic [3:0] op_pos;
  logic [3:0] ol;
  logic [1:0] map;
  logic [7:0] o;
  logic [3:0] mpos;
  logic [7:0] modrm;
  logic [2:0] sib_base;
  logic       modrm_en;
  logic       sib_en;
  logic [3:0] disp;
  logic [3:0] imm;
  logic       ill_op;
  logic [5:0] len;
  logic       ill;
  logic       active;

  function automatic logic is_pfx(input logic [7:0] x);
    return x inside {8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
                     8'h26, 8'h64, 8'h65, 8'h66, 8'h67};
  endfunction

  function automatic logic m0_modrm(input logic [7:0] x);
    return (x < 8'h40 && !x[2]) ||
      x inside {8'h63, 8'h69, 8'h6B, [8'h80:8'h8F], 8'hC0, 8'hC1,
                8'hC6, 8'hC7, [8'hD0:8'hD3], [8'hD8:8'hDF],
                8'hF6, 8'hF7, 8'hFE, 8'hFF};
  endfunction

  function automatic logic m0_illegal(input logic [7:0] x);
    return x inside {8'h06, 8'h07, 8'h0E, 8'h16, 8'h17, 8'h1E,
                     8'h1F, 8'h27, 8'h2F, 8'h37, 8'h3F, 8'h60,
                     8'h61, 8'h62, 8'h82, 8'h9A, 8'hC4, 8'hC5,
                     8'hD4, 8'hD5, 8'hD6, 8'hEA, 8'hCE};
  endfunction

  function automatic logic [3:0] m0_imm(
    input logic [7:0] x,
    input logic [2:0] rg,
    input logic       o16,
    input logic       rw,
    input logic       a32
  );
    logic [3:0] z;
    z = o16 ? 4'd2 : 4'd4;
    if ((x < 8'h40 && x[2:0] == 3'd4) ||
        x inside {8'h6A, 8'h6B, [8'h70:8'h7F], 8'h80, 8'h83,
                  8'hA8, [8'hB0:8'hB7], 8'hC0, 8'hC1, 8'hC6,
                  8'hCD, [8'hE0:8'hE7], 8'hEB} ||
        (x == 8'hF6 && rg[2:1] == 2'd0))
      return 4'd1;
    else if ((x < 8'h40 && x[2:0] == 3'd5) ||
             x inside {8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7,
                       8'hE8, 8'hE9} ||
             (x == 8'hF7 && rg[2:1] == 2'd0))
      return z;
    else if (x inside {[8'hB8:8'hBF]})
      return rw ? 4'd8 : z;
    else if (x == 8'hC2 || x == 8'hCA)
      return 4'd2;
    else if (x == 8'hC8)
      return 4'd3;
    else if (x inside {[8'hA0:8'hA3]})
      return a32 ? 4'd4 : 4'd8;
    else
      return 4'd0;
  endfunction

  function automatic logic m1_nomodrm(input logic [7:0] x);
    return x inside {[8'h05:8'h09], 8'h0B, 8'h0E, [8'h30:8'h37],
                     8'h77, [8'h80:8'h8F], [8'hA0:8'hA2],
                     [8'hA8:8'hAA], [8'hC8:8'hCF]};
  endfunction

  function automatic logic [3:0] m1_imm(input logic [7:0] x);
    if (x inside {[8'h70:8'h73], 8'hA4, 8'hAC, 8'hBA, 8'hC2,
                  [8'hC4:8'hC6]})
      return 4'd1;
    else if (x inside {[8'h80:8'h8F]})
      return 4'd4;
    else
      return 4'd0;
  endfunction

  // Split the window into bytes; the spare slot keeps indexing in range.
  always_comb begin
    for (int k = 0; k < 15; k++) b[k] = decode_bytes[k*8 +: 8];
    b[15] = 8'h00;
  end

  // Walk prefixes, REX, opcode, ModRM/SIB and sum the instruction length.
  always_comb begin
    pc   = 4'd0;
    stop = 1'b0;
    p66  = 1'b0;
    p67  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!stop && is_pfx(b[i])) begin
        pc = pc + 4'd1;
        if (b[i] == 8'h66) p66 = 1'b1;
        if (b[i] == 8'h67) p67 = 1'b1;
      end else begin
        stop = 1'b1;
      end
    end
    too_many = (pc == 4'd4) && is_pfx(b[4]);
    rex_hit  = (b[pc][7:4] == 4'h4);
    w        = rex_hit & b[pc][3];
    osz16    = p66 & ~w;
    op_pos   = pc + {3'd0, rex_hit};
    map = 2'd0;
    ol  = 4'd1;
    o   = b[op_pos];
    if (b[op_pos] == 8'h0F) begin
      if (b[op_pos + 4'd1] == 8'h38) begin
        map = 2'd2;
        ol  = 4'd3;
        o   = b[op_pos + 4'd2];
      end else if (b[op_pos + 4'd1] == 8'h3A) begin
        map = 2'd3;
        ol  = 4'd3;
        o   = b[op_pos + 4'd2];
      end else begin
        map = 2'd1;
        ol  = 4'd2;
        o   = b[op_pos + 4'd1];
      end
    end
    mpos     = op_pos + ol;
    modrm    = b[mpos];
    sib_base = b[mpos + 4'd1][2:0];
    modrm_en = 1'b0;
    imm      = 4'd0;
    ill_op   = 1'b0;
    case (map)
      2'd0: begin
        modrm_en = m0_modrm(o);
        ill_op   = m0_illegal(o);
        imm      = m0_imm(o, modrm[5:3], osz16, w, p67);
      end
      2'd1: begin
        modrm_en = ~m1_nomodrm(o);
        imm      = m1_imm(o);
      end
      2'd2: modrm_en = 1'b1;
      default: begin
        modrm_en = 1'b1;
        imm      = 4'd1;
      end
    endcase
    sib_en = modrm_en && modrm[7:6] != 2'd3 && modrm[2:0] == 3'd4;
    disp   = 4'd0;
    if (modrm_en) begin
      if (modrm[7:6] == 2'd1)
        disp = 4'd1;
      else if (modrm[7:6] == 2'd2)
        disp = 4'd4;
      else if (modrm[7:6] == 2'd0 && modrm[2:0] == 3'd5)
        disp = 4'd4;
      else if (modrm[7:6] == 2'd0 && sib_en && sib_base == 3'd5)
        disp = 4'd4;
    end
    len = {2'b0, op_pos} + {2'b0, ol} + {5'b0, modrm_en} +
          {5'b0, sib_en} + {2'b0, disp} + {2'b0, imm};
    ill = too_many | ill_op | (len > 6'd15);
  end

  // Gate results with valid and reset; an illegal start consumes nothing.
  always_comb begin
    active        = valid & ~reset;
    bytes_decoded = (active & ~ill) ? len[3:0] : 4'd0;
    illegal       = active & ill;
    has_modrm     = active & ~ill & modrm_en;
    opcode_map    = (active & ~ill) ? map : 2'd0;
  end

  // Count consumed instructions and latch any illegal window.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_count   <= 32'd0;
      illegal_seen <= 1'b0;
    end else begin
      if (bytes_decoded != 4'd0) inst_count <= inst_count + 32'd1;
      if (illegal) illegal_seen <= 1'b1;
    end
  end

`ifdef INST_DECODER_TRACE_EN
  // Simulation trace of every consumed or rejected instruction.
  always @(posedge clk) begin
    if (bytes_decoded != 4'd0)
      $display("inst_decoder: win=%h len=%0d map=%0d op=%h",
               decode_bytes, bytes_decoded, opcode_map, o);
    if (illegal)
      $display("inst_decoder: error: illegal instruction win=%h",
               decode_bytes);
  end
`endif

endmodule

// File: tb/tb_inst_decoder.sv
// Directed-vector bench for inst_decoder.
// Each step checks registered state, then the combinational decode.
module tb_inst_decoder;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [0:119] decode_bytes;
  logic [3:0]   bytes_decoded;
  logic         illegal;
  logic         has_modrm;
  logic [1:0]   opcode_map;
  logic [31:0]  inst_count;
  logic         illegal_seen;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_cnt = 32'd0;
  logic        exp_seen = 1'b0;

  inst_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .valid        (valid),
    .decode_bytes (decode_bytes),
    .bytes_decoded(bytes_decoded),
    .illegal      (illegal),
    .has_modrm    (has_modrm),
    .opcode_map   (opcode_map),
    .inst_count   (inst_count),
    .illegal_seen (illegal_seen)
  );

  always #5 clk = ~clk;

  function automatic logic [119:0] lj(input logic [119:0] v, input int n);
    return v << (8 * (15 - n));
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic v,
                      input logic [119:0] win, input logic [3:0] elen,
                      input logic eill, input logic emod,
                      input logic [1:0] emap);
    @(negedge clk);
    check({tag, ".count"}, inst_count, exp_cnt);
    check({tag, ".seen"}, {31'd0, illegal_seen}, {31'd0, exp_seen});
    reset        = rst;
    valid        = v;
    decode_bytes = win;
    #1;
    check({tag, ".len"}, {28'd0, bytes_decoded}, {28'd0, elen});
    check({tag, ".ill"}, {31'd0, illegal}, {31'd0, eill});
    check({tag, ".modrm"}, {31'd0, has_modrm}, {31'd0, emod});
    check({tag, ".map"}, {30'd0, opcode_map}, {30'd0, emap});
    if (rst) begin
      exp_cnt  = 32'd0;
      exp_seen = 1'b0;
    end else begin
      if (elen != 4'd0) exp_cnt = exp_cnt + 32'd1;
      if (eill) exp_seen = 1'b1;
    end
  endtask

  initial begin
    reset        = 1'b1;
    valid        = 1'b0;
    decode_bytes = '0;
    repeat (2) @(posedge clk);
    step("rst_hold", 1, 1, lj(120'h90, 1), 0, 0, 0, 0);
    step("mov_rr", 0, 1, lj(120'h4889E5, 3), 3, 0, 1, 0);
    step("movabs", 0, 1, lj(120'h48B8_1122334455667788, 10),
         10, 0, 0, 0);
    step("mov16", 0, 1, lj(120'h66B83412, 4), 4, 0, 0, 0);
    step("nopw", 0, 1, lj(120'h660F1F440000, 6), 6, 0, 1, 1);
    step("map3", 0, 1, lj(120'h0F3A0FC108, 5), 5, 0, 1, 3);
    step("riprel", 0, 1, lj(120'h488B05_11223344, 7), 7, 0, 1, 0);
    step("sib_imm", 0, 1, lj(120'hC78424_11223344_55667788, 11),
         11, 0, 1, 0);
    step("f6_test", 0, 1, lj(120'hF6C012, 3), 3, 0, 1, 0);
    step("f6_not", 0, 1, lj(120'hF6D0, 2), 2, 0, 1, 0);
    step("map2", 0, 1, lj(120'h0F3800C1, 4), 4, 0, 1, 2);
    step("jcc32", 0, 1, lj(120'h0F84_11223344, 6), 6, 0, 0, 1);
    step("moffs32", 0, 1, lj(120'h67A1_11223344, 6), 6, 0, 0, 0);
    step("moffs64", 0, 1, lj(120'hA1_1122334455667788, 9),
         9, 0, 0, 0);
    step("pfx4", 0, 1, lj(120'h6666666690, 5), 5, 0, 0, 0);
    step("over15", 0, 1, lj(120'h64652E3E48C78424, 8), 0, 1, 0, 0);
    step("op06", 0, 1, lj(120'h06, 1), 0, 1, 0, 0);
    step("pfx5", 0, 1, lj(120'h666666666690, 6), 0, 1, 0, 0);
    step("invalid", 0, 0, lj(120'h90, 1), 0, 0, 0, 0);
    step("reset", 1, 1, lj(120'h90, 1), 0, 0, 0, 0);
    step("nop1", 0, 1, lj(120'h90, 1), 1, 0, 0, 0);
    step("nop2", 0, 1, lj(120'h90, 1), 1, 0, 0, 0);
    step("nop3", 0, 1, lj(120'h90, 1), 1, 0, 0, 0);
    @(negedge clk);
    valid = 1'b0;
    check("final.count", inst_count, 32'd3);
    check("final.seen", {31'd0, illegal_seen}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
